// File: rtl/cv32e40p_voter_pkg.sv
// Shared types for the TMR voter manager and its combinational voting core.
// Optional feature macro used by the manager: CV32E40P_VOTER_DECAY_EN.
package cv32e40p_voter_pkg;

  typedef enum logic [1:0] {
    VS_HEALTHY  = 2'd0,
    VS_DEGRADED = 2'd1,
    VS_FAILED   = 2'd2
  } voter_state_e;

  // Width-independent part of a vote result; the voted data word is carried
  // alongside it because its width is a parameter of the instantiating module.
  typedef struct packed {
    logic [2:0] mismatch;
    logic       corrected;
    logic       uncorr;
  } vote_flags_t;

  localparam vote_flags_t VOTE_FLAGS_CLEAN = '{mismatch: 3'b000, corrected: 1'b0, uncorr: 1'b0};

endpackage

// File: rtl/cv32e40p_voter_core.sv
// Purely combinational voter: majority vote while no replica is retired,
// duplex compare of the two survivors once one is retired.
module cv32e40p_voter_core
  import cv32e40p_voter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [2:0]       broken,
  output logic [WIDTH-1:0] voted,
  output vote_flags_t      flags
);

  typedef struct packed {
    logic [WIDTH-1:0] voted;
    vote_flags_t      flags;
  } vote_res_t;

  vote_res_t res;
  logic      eq_12;
  logic      eq_13;
  logic      eq_23;

  assign eq_12 = (in_1 == in_2);
  assign eq_13 = (in_1 == in_3);
  assign eq_23 = (in_2 == in_3);

  // Select voted word and flags from the pairwise equalities and retired mask.
  always_comb begin
    res.voted = in_1;
    res.flags = VOTE_FLAGS_CLEAN;
    case (broken)
      3'b000: begin
        if (eq_12 && eq_13) begin
          res.voted = in_1;
        end else if (eq_12) begin
          res.voted              = in_1;
          res.flags.mismatch     = 3'b100;
          res.flags.corrected    = 1'b1;
        end else if (eq_13) begin
          res.voted              = in_1;
          res.flags.mismatch     = 3'b010;
          res.flags.corrected    = 1'b1;
        end else if (eq_23) begin
          res.voted              = in_2;
          res.flags.mismatch     = 3'b001;
          res.flags.corrected    = 1'b1;
        end else begin
          res.voted              = in_1;
          res.flags.mismatch     = 3'b111;
          res.flags.uncorr       = 1'b1;
        end
      end
      3'b001: begin
        res.voted          = in_2;
        res.flags.uncorr   = !eq_23;
        res.flags.mismatch = eq_23 ? 3'b000 : 3'b110;
      end
      3'b010: begin
        res.voted          = in_1;
        res.flags.uncorr   = !eq_13;
        res.flags.mismatch = eq_13 ? 3'b000 : 3'b101;
      end
      3'b100: begin
        res.voted          = in_1;
        res.flags.uncorr   = !eq_12;
        res.flags.mismatch = eq_12 ? 3'b000 : 3'b011;
      end
      default: begin
        // More than one replica retired: nothing left to trust.
        res.voted          = in_1;
        res.flags.uncorr   = 1'b1;
        res.flags.mismatch = 3'b000;
      end
    endcase
  end

  assign voted = res.voted;
  assign flags = res.flags;

endmodule

// File: rtl/cv32e40p_tmr_voter_mgr.sv
// TMR voter manager: registered vote output stage, per-replica error
// counters, replica retirement and HEALTHY/DEGRADED/FAILED health FSM.
// Optional counter decay on clean votes: define CV32E40P_VOTER_DECAY_EN.
module cv32e40p_tmr_voter_mgr
  import cv32e40p_voter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 4,
  parameter int THRESH  = 3,
  parameter int DECAY_P = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   in_1_i,
  input  logic [WIDTH-1:0]   in_2_i,
  input  logic [WIDTH-1:0]   in_3_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH-1:0]   voted_o,
  output logic [2:0]         err_detected_o,
  output logic               err_corrected_o,
  output logic               err_uncorr_o,
  output logic [2:0]         broken_o,
  output logic [1:0]         state_o,
  output logic [3*CNT_W-1:0] err_cnt_o,
  output logic               fatal_o
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  voter_state_e     state_r, state_n;
  logic [CNT_W-1:0] cnt_r [3];
  logic [CNT_W-1:0] cnt_n [3];
  logic [2:0]       broken_r, broken_n;
  logic             valid_r;
  logic [WIDTH-1:0] voted_r;
  logic [2:0]       det_r;
  logic             corr_r;
  logic             uncorr_r;

  logic             acc_s;
  logic [WIDTH-1:0] core_voted_s;
  vote_flags_t      core_flags_s;

`ifdef CV32E40P_VOTER_DECAY_EN
  localparam int CLEAN_W = (DECAY_P > 1) ? $clog2(DECAY_P) : 1;
  localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(DECAY_P - 1);
  logic [CLEAN_W-1:0] clean_r, clean_n;
`endif

  cv32e40p_voter_core #(.WIDTH(WIDTH)) u_core (
    .in_1   (in_1_i),
    .in_2   (in_2_i),
    .in_3   (in_3_i),
    .broken (broken_r),
    .voted  (core_voted_s),
    .flags  (core_flags_s)
  );

  assign ready_o = !valid_r || ready_i;
  assign acc_s   = valid_i && ready_o;

  // Health bookkeeping: counter updates, retirement and state transitions.
  always_comb begin
    state_n  = state_r;
    broken_n = broken_r;
    for (int k = 0; k < 3; k++) cnt_n[k] = cnt_r[k];
`ifdef CV32E40P_VOTER_DECAY_EN
    clean_n = clean_r;
`endif
    if (clear_i) begin
      // A vote accepted together with clear still gets flagged, but its
      // bookkeeping is discarded in favour of the clean slate.
      state_n  = VS_HEALTHY;
      broken_n = 3'b000;
      for (int k = 0; k < 3; k++) cnt_n[k] = '0;
`ifdef CV32E40P_VOTER_DECAY_EN
      clean_n = '0;
`endif
    end else if (acc_s) begin
      case (state_r)
        VS_HEALTHY: begin
          if (core_flags_s.corrected) begin
            for (int k = 0; k < 3; k++) begin
              if (core_flags_s.mismatch[k] && (cnt_r[k] != CNT_MAX)) begin
                cnt_n[k] = cnt_r[k] + CNT_ONE;
                if ((cnt_r[k] + CNT_ONE) == CNT_THRESH) begin
                  broken_n[k] = 1'b1;
                  state_n     = VS_DEGRADED;
                end else begin
                  broken_n[k] = broken_r[k];
                end
              end else begin
                cnt_n[k] = cnt_r[k];
              end
            end
`ifdef CV32E40P_VOTER_DECAY_EN
            clean_n = '0;
`endif
          end else if (core_flags_s.uncorr) begin
`ifdef CV32E40P_VOTER_DECAY_EN
            clean_n = '0;
`endif
            state_n = VS_HEALTHY;
          end else begin
`ifdef CV32E40P_VOTER_DECAY_EN
            // Clean vote: every DECAY_P of them forgive one error per replica.
            if (clean_r == CLEAN_LAST) begin
              clean_n = '0;
              for (int k = 0; k < 3; k++) begin
                if (!broken_r[k] && (cnt_r[k] != '0)) begin
                  cnt_n[k] = cnt_r[k] - CNT_ONE;
                end else begin
                  cnt_n[k] = cnt_r[k];
                end
              end
            end else begin
              clean_n = clean_r + CLEAN_W'(1);
            end
`endif
            state_n = VS_HEALTHY;
          end
        end
        VS_DEGRADED: begin
          if (core_flags_s.uncorr) begin
            state_n = VS_FAILED;
          end else begin
            state_n = VS_DEGRADED;
          end
        end
        VS_FAILED: begin
          state_n = VS_FAILED;
        end
        default: begin
          state_n = VS_FAILED;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Health state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= VS_HEALTHY;
      broken_r <= 3'b000;
      for (int k = 0; k < 3; k++) cnt_r[k] <= '0;
`ifdef CV32E40P_VOTER_DECAY_EN
      clean_r  <= '0;
`endif
    end else begin
      state_r  <= state_n;
      broken_r <= broken_n;
      for (int k = 0; k < 3; k++) cnt_r[k] <= cnt_n[k];
`ifdef CV32E40P_VOTER_DECAY_EN
      clean_r  <= clean_n;
`endif
    end
  end

  // One-entry output stage: capture on accept, hold under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r  <= 1'b0;
      voted_r  <= '0;
      det_r    <= 3'b000;
      corr_r   <= 1'b0;
      uncorr_r <= 1'b0;
    end else if (acc_s) begin
      valid_r  <= 1'b1;
      voted_r  <= core_voted_s;
      det_r    <= core_flags_s.mismatch;
      corr_r   <= core_flags_s.corrected;
      uncorr_r <= core_flags_s.uncorr || (state_r == VS_FAILED);
    end else if (ready_i) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  assign valid_o         = valid_r;
  assign voted_o         = voted_r;
  assign err_detected_o  = det_r;
  assign err_corrected_o = corr_r;
  assign err_uncorr_o    = uncorr_r;
  assign broken_o        = broken_r;
  assign state_o         = state_r;
  assign err_cnt_o       = {cnt_r[2], cnt_r[1], cnt_r[0]};
  assign fatal_o         = (state_r == VS_FAILED);

endmodule
